pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register replacing the bare struct-typed ID/EXE/MEM/WB registers. Carries an opaque payload (sized with `$bits` of the stage struct) between stages with valid/ready flow control, synchronous flush and an optional two-entry skid buffer, so `ready` toward the upstream stage is registered. Instantiated once per stage boundary in the 5-stage core; also exports a bubble counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 84 ++++++++
 tb/tb_pipe_stage_reg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with optional two-entry skid buffer and bubble counter
module pipe_stage_reg #(
    parameter int               WIDTH   = 32,
    parameter int               SKID    = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_main, r_skid, w_main, w_skid;
    logic [CNT_W-1:0] r_bubble;
    logic             w_in_fire, w_out_fire;

    assign out_valid  = r_state != EMPTY;
    assign in_ready   = (SKID != 0) ? (r_state != FULL) : (!out_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign out_data   = r_main;
    assign occupancy  = r_state;
    assign bubble_cnt = r_bubble;

    // next state and storage updates; flush overrides every transition
    always_comb begin
        w_next = r_state;
        w_main = r_main;
        w_skid = r_skid;
        case (r_state)
            EMPTY: if (w_in_fire) begin
                w_next = ONE;
                w_main = in_data;
            end
            ONE: if (w_in_fire && w_out_fire) begin
                w_main = in_data;
            end else if (w_in_fire && SKID != 0) begin
                w_next = FULL;
                w_skid = in_data;
            end else if (w_out_fire) begin
                w_next = EMPTY;
            end
            FULL: if (w_out_fire) begin
                w_next = ONE;
                w_main = r_skid;
            end
            default: w_next = EMPTY;
        endcase
        if (flush) begin
            w_next = EMPTY;
            w_main = RST_VAL;
            w_skid = RST_VAL;
        end
    end

    // state and payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= RST_VAL;
            r_skid  <= RST_VAL;
        end else begin
            r_state <= w_next;
            r_main  <= w_main;
            r_skid  <= w_skid;
        end
    end

    // saturating count of cycles where downstream was ready but nothing was offered
    always_ff @(posedge clk) begin
        if (rst) r_bubble <= '0;
        else if (out_ready && !out_valid && r_bubble != '1) r_bubble <= r_bubble + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for the skid and non-skid stage variants
module tb_pipe_stage_reg;
    logic        clk = 0, rst;
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [3:0]  a_bub;
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_bub;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .occupancy(a_occ), .bubble_cnt(a_bub)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .occupancy(b_occ), .bubble_cnt(b_bub)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        a_flush = 0; a_in_valid = 1; a_in_data = 32'hDEAD_BEEF; a_out_ready = 0;
        b_flush = 0; b_in_valid = 1; b_in_data = 32'hDEAD_BEEF; b_out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_valid", a_out_valid, 0);
            check("rst_data", a_out_data, 0);
            check("rst_ready", a_in_ready, 1);
            check("rst_occ", a_occ, 0);
        end
        rst = 0; a_in_valid = 0; b_in_valid = 0;
        step();
        check("post_rst_valid", a_out_valid, 0);
        check("post_rst_occ", a_occ, 0);
        check("post_rst_ready", a_in_ready, 1);
        check("post_rst_bub", a_bub, 0);
        check("post_rst_b_valid", b_out_valid, 0);

        a_in_valid = 1; a_in_data = 1;
        step();
        check("stream_v1", a_out_valid, 1);
        check("stream_d1", a_out_data, 1);
        check("stream_o1", a_occ, 1);
        a_out_ready = 1;
        for (int i = 2; i <= 4; i++) begin
            a_in_data = i;
            step();
            check("stream_d", a_out_data, i);
            check("stream_o", a_occ, 1);
        end
        a_in_valid = 0;
        step();
        a_out_ready = 0;
        check("stream_end_valid", a_out_valid, 0);
        check("stream_end_occ", a_occ, 0);
        check("stream_bub", a_bub, 0);

        a_in_valid = 1; a_in_data = 32'hA;
        step();
        check("skid_o1", a_occ, 1);
        check("skid_r1", a_in_ready, 1);
        a_in_data = 32'hB;
        step();
        check("skid_o2", a_occ, 2);
        check("skid_r2", a_in_ready, 0);
        check("skid_dA", a_out_data, 32'hA);
        a_in_valid = 0; a_out_ready = 1;
        #1;
        check("skid_ready_reg", a_in_ready, 0);
        step();
        check("skid_dB", a_out_data, 32'hB);
        check("skid_o_after", a_occ, 1);
        check("skid_r_after", a_in_ready, 1);
        step();
        a_out_ready = 0;
        check("skid_drain_valid", a_out_valid, 0);

        a_in_valid = 1; a_in_data = 32'h1;
        step();
        a_in_data = 32'h2;
        step();
        check("full_again", a_occ, 2);
        a_flush = 1; a_in_data = 32'hC;
        step();
        a_flush = 0; a_in_valid = 0;
        check("flush_full_occ", a_occ, 0);
        check("flush_full_valid", a_out_valid, 0);
        check("flush_full_data", a_out_data, 0);
        step();
        check("flush_no_C", a_out_valid, 0);

        a_in_valid = 1; a_in_data = 32'h7;
        step();
        a_flush = 1; a_in_data = 32'hD;
        check("flush_one_ready", a_in_ready, 1);
        step();
        a_flush = 0; a_in_valid = 0;
        check("flush_one_occ", a_occ, 0);
        check("flush_one_data", a_out_data, 0);
        check("pre_bub", a_bub, 0);

        b_in_valid = 1; b_in_data = 32'h5;
        step();
        check("b_occ1", b_occ, 1);
        check("b_d5", b_out_data, 32'h5);
        check("b_ready_low", b_in_ready, 0);
        b_out_ready = 1; b_in_data = 32'h6;
        #1;
        check("b_ready_comb", b_in_ready, 1);
        step();
        check("b_d6", b_out_data, 32'h6);
        check("b_occ_pass", b_occ, 1);
        b_in_valid = 0;
        step();
        b_out_ready = 0;
        check("b_empty", b_occ, 0);

        a_out_ready = 1;
        for (int i = 0; i < 10; i++) step();
        check("bub_10", a_bub, 10);
        for (int i = 0; i < 10; i++) step();
        check("bub_sat", a_bub, 15);
        a_flush = 1;
        step();
        a_flush = 0;
        check("bub_flush", a_bub, 15);
        rst = 1;
        step();
        rst = 0;
        check("bub_rst", a_bub, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
